// File: rtl/spi_frame_arbiter_pkg.sv
// Shared definitions for the SPI frame arbiter: frame width and FSM encoding.
// SPI_W is common to SPI_MASTER, SPI_SLAVE and MUX64_16.
package spi_arb_pkg;

  localparam int SPI_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_DONE    = 3'd5,
    ST_ABORT   = 3'd6
  } arb_state_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_frame_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or above
// ptr, wrapping past N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt,
  output logic          any
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] req_shift;
  logic [N-1:0]   req_rot;

  // Rotating the doubled vector puts requester ptr at bit 0.
  assign req_dbl   = {req, req};
  assign req_shift = req_dbl >> ptr;
  assign req_rot   = req_shift[N-1:0];

  always_comb begin
    logic [N-1:0] rot_k;
    int           sum;
    gnt   = '0;
    any   = 1'b0;
    rot_k = '0;
    sum   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      rot_k = req_rot >> k;
      if (rot_k[0]) begin
        sum = int'(ptr) + k;
        if (sum >= N) sum = sum - N;
        gnt = PW'(sum);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_frame_arbiter.sv
// Round-robin arbiter sharing one SPI master among N requesters, with a
// saturating watchdog that aborts frames that never start or never finish.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no frame; pick next requester from ptr
// GRANT    | load spi_di from the winner, advance ptr, raise spi_st
// START    | spi_st high this cycle; watchdog cleared
// WAIT_LO  | waiting for LOAD low (frame running); START_TO guard
// WAIT_HI  | waiting for LOAD high (frame end); all-ones guard
// DONE     | ack[gnt] high, rx_dat valid
// ABORT    | err[gnt] high, rx_dat unchanged
module spi_frame_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int START_TO = 255,
  parameter int TO_W     = 20
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [N-1:0]       req,
  input  logic [SPI_W*N-1:0] req_dat,
  output logic [N-1:0]       ack,
  output logic [N-1:0]       err,
  output logic [SPI_W-1:0]   rx_dat,
  output logic               busy,
  output logic               spi_st,
  output logic [SPI_W-1:0]   spi_di,
  input  logic [SPI_W-1:0]   spi_do,
  input  logic               spi_load
);

  localparam int PW = ptr_width(N);

  arb_state_t         state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      gnt;
  logic [PW-1:0]      pick;
  logic               pick_any;
  logic [TO_W-1:0]    wd;
  logic [TO_W-1:0]    wd_inc;
  logic               wd_sat;
  logic               start_expired;
  logic [N-1:0]       gnt_oh;
  logic [PW-1:0]      ptr_next;
  logic [SPI_W*N-1:0] dat_shift;
  logic [SPI_W-1:0]   sel_dat;

  rr_pick #(.N(N), .PW(PW)) u_rr_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick),
    .any (pick_any)
  );

  assign wd_sat = &wd;
  assign wd_inc = wd_sat ? wd : wd + TO_W'(1);
  // The saturation term keeps WAIT_LO from hanging if START_TO exceeds the counter range.
  assign start_expired = (32'(wd) == 32'(START_TO)) || wd_sat;

  assign gnt_oh    = {{(N-1){1'b0}}, 1'b1} << gnt;
  assign ptr_next  = (gnt == PW'(N - 1)) ? '0 : gnt + PW'(1);
  assign dat_shift = req_dat >> (int'(gnt) * SPI_W);
  assign sel_dat   = dat_shift[SPI_W-1:0];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      gnt    <= '0;
      ack    <= '0;
      err    <= '0;
      busy   <= 1'b0;
      spi_st <= 1'b0;
      spi_di <= '0;
      rx_dat <= '0;
      wd     <= '0;
    end else begin
      spi_st <= 1'b0;
      ack    <= '0;
      err    <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt   <= pick;
            busy  <= 1'b1;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          spi_di <= sel_dat;
          ptr    <= ptr_next;
          spi_st <= 1'b1;
          state  <= ST_START;
        end
        ST_START: begin
          wd    <= '0;
          state <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          // A level check: LOAD already low here means the frame is under way.
          if (!spi_load) begin
            wd    <= '0;
            state <= ST_WAIT_HI;
          end else if (start_expired) begin
            err   <= gnt_oh;
            state <= ST_ABORT;
          end else begin
            wd <= wd_inc;
          end
        end
        ST_WAIT_HI: begin
          if (spi_load) begin
            rx_dat <= spi_do;
            ack    <= gnt_oh;
            state  <= ST_DONE;
          end else begin
            wd <= wd_inc;
            if (&wd_inc) begin
              err   <= gnt_oh;
              state <= ST_ABORT;
            end
          end
        end
        ST_DONE, ST_ABORT: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Scoreboard bench for spi_frame_arbiter with a behavioural SPI master model.
module tb_spi_frame_arbiter;
  import spi_arb_pkg::*;

  localparam int N        = 4;
  localparam int START_TO = 10;
  localparam int TO_W     = 4;

  logic           clk = 1'b0;
  logic           clr_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [9*N-1:0] req_dat;
  logic [N-1:0]   ack, err;
  logic [8:0]     rx_dat, spi_di, spi_do;
  logic           busy, spi_st, spi_load;

  always #5 clk = ~clk;

  spi_frame_arbiter #(.N(N), .START_TO(START_TO), .TO_W(TO_W)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .req      (req),
    .req_dat  (req_dat),
    .ack      (ack),
    .err      (err),
    .rx_dat   (rx_dat),
    .busy     (busy),
    .spi_st   (spi_st),
    .spi_di   (spi_di),
    .spi_do   (spi_do),
    .spi_load (spi_load)
  );

  typedef struct {
    bit         is_err;
    logic [N-1:0] oh;
    logic [8:0] rx;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] di_q[$];
  exp_t       cur;
  logic [8:0] mdi;

  int vectors = 0, miscompares = 0;
  int cyc = 0, ev_cnt = 0, st_cnt = 0;
  int err_cyc = 0, st_cyc = 0, drop_cyc = 0;
  int mode = 0;            // 0 normal frame, 1 LOAD stuck high, 2 LOAD stuck low
  int flen = 5;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic push_ev(input bit is_err, input logic [N-1:0] oh, input logic [8:0] rx);
    exp_t e;
    e.is_err = is_err;
    e.oh     = oh;
    e.rx     = rx;
    exp_q.push_back(e);
  endtask

  task automatic wait_ev(input int target, input int budget, input string name);
    int n = 0;
    while (ev_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (ev_cnt < target) chk({name, "_timeout"}, 64'(ev_cnt), 64'(target));
  endtask

  // Monitor: completion/abort events and start pulses.
  always @(negedge clk) begin
    if (clr_n && (ack != 0 || err != 0)) begin
      ev_cnt++;
      if (err != 0) err_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("event_queue", 64'(exp_q.size()), 64'd1);
      end else begin
        cur = exp_q.pop_front();
        chk("ack", 64'(ack), cur.is_err ? 64'd0 : 64'(cur.oh));
        chk("err", 64'(err), cur.is_err ? 64'(cur.oh) : 64'd0);
        chk("rx_dat", 64'(rx_dat), 64'(cur.rx));
      end
    end
    if (clr_n && spi_st) begin
      st_cnt++;
      if (di_q.size() == 0) chk("st_queue", 64'(di_q.size()), 64'd1);
      else chk("spi_di", 64'(spi_di), 64'(di_q.pop_front()));
    end
  end

  // SPI master model: returns the complement of the word it was given.
  initial begin
    spi_load = 1'b1;
    spi_do   = '0;
    forever begin
      @(negedge clk);
      if (clr_n && spi_st) begin
        mdi    = spi_di;
        st_cyc = cyc;
        if (mode == 0) begin
          @(negedge clk);
          spi_load = 1'b0;
          repeat (flen) @(negedge clk);
          spi_do   = ~mdi;
          spi_load = 1'b1;
        end else if (mode == 2) begin
          spi_load = 1'b0;
          drop_cyc = cyc;
          wait (mode != 2);
          spi_load = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base, st0, drops, n;
    req_dat = {9'h04C, 9'h122, 9'h0F3, 9'h1A5};
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({ack, err, busy, spi_st, spi_di, rx_dat}), 64'd0);
    clr_n = 1'b1;
    @(negedge clk);

    // Single request: start pulse two cycles after req.
    di_q.push_back(9'h1A5);
    push_ev(0, 4'b0001, 9'h05A);
    st0 = st_cnt; base = ev_cnt; drops = 0; n = 0;
    req = 4'b0001;
    @(negedge clk);
    chk("busy_t1", 64'(busy), 64'd1);
    chk("st_t1", 64'(spi_st), 64'd0);
    @(negedge clk);
    chk("st_t2", 64'(spi_st), 64'd1);
    chk("di_t2", 64'(spi_di), 64'h1A5);
    while (ev_cnt < base + 1 && n < 50) begin
      @(negedge clk); #1;
      if (!busy) drops++;
      n++;
    end
    req = '0;
    chk("single_done", 64'(ev_cnt), 64'(base + 1));
    chk("busy_held", 64'(drops), 64'd0);
    chk("st_count", 64'(st_cnt - st0), 64'd1);
    @(negedge clk);
    chk("busy_fall", 64'(busy), 64'd0);

    // Reset while idle so contention starts from ptr 0.
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);

    // Contention: all four held, order 0,1,2,3,0.
    di_q.push_back(9'h1A5); push_ev(0, 4'b0001, 9'h05A);
    di_q.push_back(9'h0F3); push_ev(0, 4'b0010, 9'h10C);
    di_q.push_back(9'h122); push_ev(0, 4'b0100, 9'h0DD);
    di_q.push_back(9'h04C); push_ev(0, 4'b1000, 9'h1B3);
    di_q.push_back(9'h1A5); push_ev(0, 4'b0001, 9'h05A);
    base = ev_cnt;
    req = 4'b1111;
    wait_ev(base + 5, 300, "contention");
    req = '0;
    repeat (6) @(negedge clk);
    chk("contention_count", 64'(ev_cnt), 64'(base + 5));

    // Single frame from requester 1 leaves ptr at 2.
    di_q.push_back(9'h0F3); push_ev(0, 4'b0010, 9'h10C);
    base = ev_cnt;
    req = 4'b0010;
    wait_ev(base + 1, 60, "ptr_setup");
    req = '0;
    repeat (2) @(negedge clk);

    // Wrap after skip: ptr 2, req 0011 -> 0 then 1.
    di_q.push_back(9'h1A5); push_ev(0, 4'b0001, 9'h05A);
    di_q.push_back(9'h0F3); push_ev(0, 4'b0010, 9'h10C);
    base = ev_cnt;
    req = 4'b0011;
    wait_ev(base + 1, 60, "wrap_first");
    req = 4'b0010;
    wait_ev(base + 2, 60, "wrap_second");
    req = '0;
    repeat (2) @(negedge clk);

    // Start timeout: LOAD never falls.
    mode = 1;
    di_q.push_back(9'h122); push_ev(1, 4'b0100, 9'h10C);
    base = ev_cnt;
    req = 4'b0100;
    wait_ev(base + 1, 80, "start_to");
    req = '0;
    chk("start_to_cycles", 64'(err_cyc - st_cyc), 64'(START_TO + 2));
    @(negedge clk);
    chk("idle_after_start_to", 64'(busy), 64'd0);
    mode = 0;
    repeat (2) @(negedge clk);

    // Frame timeout: LOAD stuck low, already low during START.
    mode = 2;
    di_q.push_back(9'h04C); push_ev(1, 4'b1000, 9'h10C);
    base = ev_cnt;
    req = 4'b1000;
    wait_ev(base + 1, 80, "frame_to");
    req = '0;
    chk("frame_to_cycles", 64'(err_cyc - drop_cyc), 64'd17);
    mode = 0;
    repeat (2) @(negedge clk);
    chk("idle_after_frame_to", 64'(busy), 64'd0);

    // Reset mid-frame in WAIT_HI.
    mode = 2;
    di_q.push_back(9'h0F3);
    st0 = st_cnt; n = 0;
    req = 4'b0010;
    while (st_cnt == st0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (6) @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    clr_n = 1'b0;
    #1;
    chk("reset_mid_frame", 64'({ack, err, busy, spi_st, spi_di, rx_dat}), 64'd0);
    req  = '0;
    mode = 0;
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    di_q.push_back(9'h122); push_ev(0, 4'b0100, 9'h0DD);
    base = ev_cnt;
    req = 4'b0100;
    wait_ev(base + 1, 60, "post_reset");
    req = '0;
    repeat (5) @(negedge clk);
    chk("queues_drained", 64'(exp_q.size() + di_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
